// File: rtl/demux_rr_scheduler_if.sv
// demux_rr_scheduler_if
//   Bundles the upstream ready/valid stream, the channel enable mask and the
//   eight-channel downstream handshake of the round-robin demux scheduler.
//
//   Signals
//     IN_DATA   [DW-1:0]  upstream data word
//     IN_VALID            upstream word valid
//     IN_READY            scheduler can accept a word this cycle
//     EN_MASK   [7:0]     per-channel enable
//     OUT_DATA  [DW-1:0]  registered word for the granted channel
//     OUT_VALID [7:0]     one-hot valid on the granted channel
//     OUT_READY [7:0]     per-channel ready (only the granted bit matters)
//     SEL       [2:0]     current channel pointer / demux select
//     BUSY                word pending downstream
//     XFER_CNT  [15:0]    completed downstream transfers, wrapping
//
//   Modports
//     master : environment side (drives stream, mask and channel readies)
//     slave  : scheduler side
interface demux_rr_scheduler_if #(
    parameter int DW = 8
);
    logic [DW-1:0] IN_DATA;
    logic          IN_VALID;
    logic          IN_READY;
    logic [7:0]    EN_MASK;
    logic [DW-1:0] OUT_DATA;
    logic [7:0]    OUT_VALID;
    logic [7:0]    OUT_READY;
    logic [2:0]    SEL;
    logic          BUSY;
    logic [15:0]   XFER_CNT;

    modport master (
        output IN_DATA,
        output IN_VALID,
        output EN_MASK,
        output OUT_READY,
        input  IN_READY,
        input  OUT_DATA,
        input  OUT_VALID,
        input  SEL,
        input  BUSY,
        input  XFER_CNT
    );

    modport slave (
        input  IN_DATA,
        input  IN_VALID,
        input  EN_MASK,
        input  OUT_READY,
        output IN_READY,
        output OUT_DATA,
        output OUT_VALID,
        output SEL,
        output BUSY,
        output XFER_CNT
    );
endinterface

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler
//   Round-robin scheduler for the 1-to-8 demux datapath. Accepts one word at a
//   time from the upstream stream, registers it, and presents it to a single
//   enabled channel until that channel's ready completes the transfer.
//   BURST consecutive words go to one channel before the pointer rotates to the
//   next enabled channel; disabled channels are skipped.
//
//   Parameters
//     DW    : data word width (1..32)
//     BURST : words per channel before rotating (1..16)
//
//   Ports
//     CLK : clock, rising edge
//     RST : asynchronous reset, active-high
//     bus : demux_rr_scheduler_if.slave (stream, mask, channel handshakes,
//           select, busy flag and transfer counter)
module demux_rr_scheduler #(
    parameter int DW    = 8,
    parameter int BURST = 1
) (
    input logic                  CLK,
    input logic                  RST,
    demux_rr_scheduler_if.slave  bus
);

    localparam int BCW = 4;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t         state;
    state_t         next_state;

    logic [2:0]     sel;
    logic [BCW-1:0] bcnt;
    logic [DW-1:0]  data_q;
    logic [15:0]    xfer_cnt;

    logic           mask_any;
    logic           in_ready;
    logic           busy;
    logic [7:0]     out_valid;
    logic           accept;
    logic           complete;

    logic [2:0]     pick_sel;
    logic [BCW-1:0] pick_bcnt;
    logic [2:0]     scan_idx;
    logic           found;

    assign mask_any = |bus.EN_MASK;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept)   next_state = SEND;
            SEND: if (complete) next_state = IDLE;
            default:            next_state = IDLE;
        endcase
    end

    // Output / handshake decode. OUT_VALID is decoded from the state register
    // so an asynchronous reset drops it immediately.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = '0;
        case (state)
            IDLE: in_ready = mask_any;
            SEND: begin
                busy           = 1'b1;
                out_valid[sel] = 1'b1;
            end
            default: ;
        endcase
        accept   = (state == IDLE) && bus.IN_VALID && in_ready;
        complete = (state == SEND) && bus.OUT_READY[sel];
    end

    // Channel pick using the mask of the accept cycle. Rotation scans
    // SEL+1 .. SEL+8 modulo 8, so the current channel is considered last.
    always_comb begin
        pick_sel  = sel;
        pick_bcnt = BCW'(BURST - 1);
        found     = 1'b0;
        scan_idx  = sel;
        if ((bcnt != '0) && bus.EN_MASK[sel]) begin
            pick_bcnt = bcnt - 1'b1;
        end else begin
            for (int unsigned k = 1; k <= 8; k++) begin
                scan_idx = sel + 3'(k);
                if (!found && bus.EN_MASK[scan_idx]) begin
                    pick_sel = scan_idx;
                    found    = 1'b1;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel      <= 3'd7;
            bcnt     <= '0;
            data_q   <= '0;
            xfer_cnt <= '0;
        end else begin
            if (accept) begin
                data_q <= bus.IN_DATA;
                sel    <= pick_sel;
                bcnt   <= pick_bcnt;
            end
            if (complete) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_DATA  = data_q;
    assign bus.OUT_VALID = out_valid;
    assign bus.SEL       = sel;
    assign bus.BUSY      = busy;
    assign bus.XFER_CNT  = xfer_cnt;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb_demux_rr_scheduler
//   Two scheduler instances (BURST=1 and BURST=3) share clock, reset, mask,
//   data and channel readies; 'which' selects the instance that receives
//   IN_VALID and whose outputs are observed. Expected grants come from a
//   behavioural model tracking the current channel and how many words of the
//   current burst it has already received.
module tb_demux_rr_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    always #5 CLK = ~CLK;

    int         which = 0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic [7:0] en_mask = '0;
    logic [7:0] out_ready = '0;

    demux_rr_scheduler_if #(.DW(8)) bus1 ();
    demux_rr_scheduler_if #(.DW(8)) bus3 ();

    demux_rr_scheduler #(.DW(8), .BURST(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
    demux_rr_scheduler #(.DW(8), .BURST(3)) dut3 (.CLK(CLK), .RST(RST), .bus(bus3));

    assign bus1.IN_VALID  = in_valid && (which == 0);
    assign bus3.IN_VALID  = in_valid && (which != 0);
    assign bus1.IN_DATA   = in_data;
    assign bus3.IN_DATA   = in_data;
    assign bus1.EN_MASK   = en_mask;
    assign bus3.EN_MASK   = en_mask;
    assign bus1.OUT_READY = out_ready;
    assign bus3.OUT_READY = out_ready;

    logic        o_ready, o_busy;
    logic [7:0]  o_valid, o_data;
    logic [2:0]  o_sel;
    logic [15:0] o_xfer;
    assign o_ready = (which != 0) ? bus3.IN_READY  : bus1.IN_READY;
    assign o_busy  = (which != 0) ? bus3.BUSY      : bus1.BUSY;
    assign o_valid = (which != 0) ? bus3.OUT_VALID : bus1.OUT_VALID;
    assign o_data  = (which != 0) ? bus3.OUT_DATA  : bus1.OUT_DATA;
    assign o_sel   = (which != 0) ? bus3.SEL       : bus1.SEL;
    assign o_xfer  = (which != 0) ? bus3.XFER_CNT  : bus1.XFER_CNT;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state per instance
    int m_ptr  [2];
    int m_run  [2];
    int m_xfer [2];
    int m_burst[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ptr[i]  = 7;
            m_run[i]  = 0;
            m_xfer[i] = 0;
        end
    endtask

    // Stay on the current channel while it is enabled and its burst is not
    // used up; otherwise move to the next enabled channel after it.
    task automatic model_pick(input int w, input logic [7:0] mask, output int ch);
        if (m_run[w] > 0 && m_run[w] < m_burst[w] && mask[m_ptr[w]]) begin
            m_run[w] = m_run[w] + 1;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                if (mask[(m_ptr[w] + k) % 8]) begin
                    m_ptr[w] = (m_ptr[w] + k) % 8;
                    break;
                end
            end
            m_run[w] = 1;
        end
        ch = m_ptr[w];
    endtask

    // One complete word: accept, 'stall' cycles of backpressure with
    // 'stall_mask' applied (optionally also clearing the granted channel's
    // enable), then completion. 'others' drives the non-granted ready lines.
    task automatic send_word(input logic [7:0] d, input logic [7:0] mask, input int stall,
                             input logic [7:0] stall_mask, input bit clr_sel,
                             input logic [7:0] others);
        int         ch;
        logic [7:0] oh;
        logic [7:0] smask;
        model_pick(which, mask, ch);
        oh = 8'd1 << ch;
        en_mask   = mask;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = others & ~oh;
        #1;
        chk("idle_in_ready", 32'(o_ready), 32'(1));
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("acc_valid", 32'(o_valid), 32'(oh));
        chk("acc_data",  32'(o_data),  32'(d));
        chk("acc_sel",   32'(o_sel),   32'(ch));
        chk("acc_busy",  32'(o_busy),  32'(1));
        chk("acc_in_ready", 32'(o_ready), 32'(0));
        smask   = clr_sel ? (stall_mask & ~oh) : stall_mask;
        en_mask = smask;
        for (int i = 0; i < stall; i++) begin
            @(posedge CLK); #1;
            chk("stall_valid", 32'(o_valid), 32'(oh));
            chk("stall_data",  32'(o_data),  32'(d));
            chk("stall_in_ready", 32'(o_ready), 32'(0));
        end
        out_ready = others | oh;
        @(posedge CLK); #1;
        m_xfer[which] = (m_xfer[which] + 1) % 65536;
        chk("done_valid", 32'(o_valid), 32'(0));
        chk("done_busy",  32'(o_busy),  32'(0));
        chk("done_xfer",  32'(o_xfer),  32'(m_xfer[which]));
        chk("done_in_ready", 32'(o_ready), 32'(smask != 0));
        out_ready = others & ~oh;
    endtask

    initial begin
        int         ch;
        logic [7:0] oh;
        m_burst[0] = 1;
        m_burst[1] = 3;
        model_reset();

        // Asynchronous reset between edges
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        for (int w = 0; w < 2; w++) begin
            which = w;
            #0;
            chk("rst_valid", 32'(o_valid), 32'(0));
            chk("rst_sel",   32'(o_sel),   32'(7));
            chk("rst_xfer",  32'(o_xfer),  32'(0));
            chk("rst_busy",  32'(o_busy),  32'(0));
        end
        which = 0;
        @(negedge CLK);
        RST = 1'b0;
        en_mask = 8'hFF;
        #1;
        chk("rst_in_ready", 32'(o_ready), 32'(1));
        @(posedge CLK); #1;

        // Full rotation, BURST=1
        which = 0;
        for (int i = 0; i < 9; i++)
            send_word(8'(8'h10 + i), 8'hFF, 0, 8'hFF, 1'b0, 8'h00);
        chk("rot_xfer9", 32'(o_xfer), 32'(9));

        // Sparse mask, unrelated readies high
        for (int i = 0; i < 4; i++)
            send_word(8'(8'h30 + i), 8'h24, 2, 8'h24, 1'b0, 8'h81);

        // Bursts of three on two channels
        which = 1;
        for (int i = 0; i < 7; i++)
            send_word(8'(8'h50 + i), 8'h03, 0, 8'h03, 1'b0, 8'h00);

        // Backpressure with the granted channel disabled mid-stall
        which = 0;
        send_word(8'hA5, 8'hFF, 5, 8'hFF, 1'b1, 8'h00);
        send_word(8'h5A, en_mask, 0, en_mask, 1'b0, 8'h00);

        // Reset while a word is pending
        model_pick(0, 8'hFF, ch);
        oh = 8'd1 << ch;
        en_mask  = 8'hFF;
        in_data  = 8'hEE;
        in_valid = 1'b1;
        out_ready = 8'h00;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("pend_valid", 32'(o_valid), 32'(oh));
        #1;
        RST = 1'b1;
        #1;
        chk("midrst_valid", 32'(o_valid), 32'(0));
        chk("midrst_sel",   32'(o_sel),   32'(7));
        chk("midrst_busy",  32'(o_busy),  32'(0));
        chk("midrst_xfer",  32'(o_xfer),  32'(0));
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        send_word(8'h77, 8'h30, 0, 8'h30, 1'b0, 8'h00);

        // Empty mask holds everything, burst count survives it
        which = 1;
        send_word(8'h61, 8'h03, 0, 8'h03, 1'b0, 8'h00);
        en_mask  = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("empty_in_ready", 32'(o_ready), 32'(0));
            @(posedge CLK); #1;
            chk("empty_valid", 32'(o_valid), 32'(0));
            chk("empty_busy",  32'(o_busy),  32'(0));
            chk("empty_sel",   32'(o_sel),   32'(m_ptr[1]));
        end
        in_valid = 1'b0;
        send_word(8'h62, 8'h03, 0, 8'h03, 1'b0, 8'h00);

        // Randomized traffic on both instances
        for (int i = 0; i < 60; i++) begin
            which = int'($urandom_range(0, 1));
            send_word(8'($urandom), 8'($urandom_range(1, 255)), int'($urandom_range(0, 3)),
                      8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
